// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg
//   Shared types and constants for the change dispenser slice.
//   cmd_e   : actuator command encoding (SODA, DIME, NICKLE).
//   state_e : dispenser FSM states.
//   COIN_*  : default coin values in 5-cent units.
package change_dispenser_pkg;

  localparam int COIN_DIME_UNITS   = 2;
  localparam int COIN_NICKLE_UNITS = 1;

  typedef enum logic [1:0] {
    CMD_SODA   = 2'd0,
    CMD_DIME   = 2'd1,
    CMD_NICKLE = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SODA   = 2'd1,
    ST_CHANGE = 2'd2
  } state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if
//   Actuator command channel (valid/ready).
//   cmd_valid : command valid (driven by master)
//   cmd       : command code, cmd_e (driven by master)
//   cmd_ready : actuator accepts the command this cycle (driven by slave)
interface change_dispenser_if;
  import change_dispenser_pkg::*;

  logic cmd_valid;
  cmd_e cmd;
  logic cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);

endinterface

// File: rtl/change_dispenser_order_fifo.sv
// order_fifo
//   Synchronous FIFO for pending purchases.
//   i_clk, i_rst_n : clock, async active-low reset
//   push, din      : write request and data (ignored when full unless popping)
//   pop, dout      : read request and head-of-queue data (show-ahead)
//   full, empty    : status
//   count          : number of stored entries (registered)
module order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A write into a full queue is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser
//   Queues purchase pulses from the vending controller and drives the
//   actuator channel: release soda, then pay change greedily in dimes,
//   falling back to nickles.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_soda, i_change   : one-cycle purchase pulse and change owed (units)
//   i_dime_empty       : dime tube empty
//   i_nickle_empty     : nickle tube empty
//   cmd_if (master)    : actuator command channel (valid/cmd/ready)
//   o_busy             : FSM not idle
//   o_pending          : queued purchases, excluding the one in service
//   o_overflow         : sticky, a purchase was dropped on a full queue
//   o_change_err       : sticky, change could not be fully paid
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | nothing in service; pops the queue head when present
//   ST_SODA   | SODA command offered, waiting for the transfer
//   ST_CHANGE | DIME/NICKLE command offered, waiting for the transfer
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int CHG_WIDTH    = 3,
  parameter int DIME_UNITS   = COIN_DIME_UNITS,
  parameter int NICKLE_UNITS = COIN_NICKLE_UNITS
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_soda,
  input  logic [CHG_WIDTH-1:0]              i_change,
  input  logic                              i_dime_empty,
  input  logic                              i_nickle_empty,
  change_dispenser_if.master                cmd_if,
  output logic                              o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_pending,
  output logic                              o_overflow,
  output logic                              o_change_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [CHG_WIDTH-1:0] DIME_V   = CHG_WIDTH'(DIME_UNITS);
  localparam logic [CHG_WIDTH-1:0] NICKLE_V = CHG_WIDTH'(NICKLE_UNITS);

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CHG_WIDTH-1:0] fifo_dout;
  logic [CNT_W-1:0]     fifo_count;

  state_e               state;
  logic [CHG_WIDTH-1:0] remaining;
  logic                 cmd_valid;
  cmd_e                 cmd;
  logic                 busy;
  logic                 overflow;
  logic                 change_err;

  logic                 xfer;
  logic [CHG_WIDTH-1:0] rem_base;
  logic                 dime_ok;
  logic                 nickle_ok;

  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

  order_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CHG_WIDTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (i_soda),
    .din     (i_change),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign xfer = cmd_valid && cmd_if.cmd_ready;

  // rem_base is what is still owed once the command now on the channel
  // completes. The next coin is chosen from it at the transfer edge so
  // commands run back-to-back, and the tube flags only matter then.
  always_comb begin
    rem_base = remaining;
    if (state == ST_CHANGE)
      rem_base = remaining - ((cmd == CMD_DIME) ? DIME_V : NICKLE_V);
    dime_ok   = (rem_base >= DIME_V)   && !i_dime_empty;
    nickle_ok = (rem_base >= NICKLE_V) && !i_nickle_empty;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      cmd_valid  <= 1'b0;
      cmd        <= CMD_SODA;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      change_err <= 1'b0;
    end else begin
      if (i_soda && fifo_full && !fifo_pop) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            remaining <= fifo_dout;
            state     <= ST_SODA;
            cmd       <= CMD_SODA;
            cmd_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_SODA, ST_CHANGE: begin
          if (xfer) begin
            if (rem_base == '0) begin
              state     <= ST_IDLE;
              remaining <= '0;
              cmd_valid <= 1'b0;
              busy      <= 1'b0;
            end else if (dime_ok) begin
              state     <= ST_CHANGE;
              remaining <= rem_base;
              cmd       <= CMD_DIME;
            end else if (nickle_ok) begin
              state     <= ST_CHANGE;
              remaining <= rem_base;
              cmd       <= CMD_NICKLE;
            end else begin
              change_err <= 1'b1;
              state      <= ST_IDLE;
              remaining  <= '0;
              cmd_valid  <= 1'b0;
              busy       <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          remaining <= '0;
          cmd_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_if.cmd_valid = cmd_valid;
  assign cmd_if.cmd       = cmd;
  assign o_busy           = busy;
  assign o_pending        = fifo_count;
  assign o_overflow       = overflow;
  assign o_change_err     = change_err;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int CHG_WIDTH  = 3;
  localparam int CNT_W      = $clog2(FIFO_DEPTH+1);

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic                 i_soda = 1'b0;
  logic [CHG_WIDTH-1:0] i_change = '0;
  logic                 i_dime_empty = 1'b0;
  logic                 i_nickle_empty = 1'b0;
  logic                 o_busy;
  logic [CNT_W-1:0]     o_pending;
  logic                 o_overflow;
  logic                 o_change_err;

  change_dispenser_if cmd_if();

  change_dispenser #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CHG_WIDTH  (CHG_WIDTH)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_soda         (i_soda),
    .i_change       (i_change),
    .i_dime_empty   (i_dime_empty),
    .i_nickle_empty (i_nickle_empty),
    .cmd_if         (cmd_if),
    .o_busy         (o_busy),
    .o_pending      (o_pending),
    .o_overflow     (o_overflow),
    .o_change_err   (o_change_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Transfer log and handshake-stability watch, sampled mid-cycle.
  cmd_e log_cmd[$];
  int   log_cyc[$];
  int   soda_cnt = 0;
  int   proto_viol = 0;
  bit   prev_stall = 0;
  cmd_e prev_cmd = CMD_SODA;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (!cmd_if.cmd_valid || cmd_if.cmd != prev_cmd))
        proto_viol++;
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        log_cmd.push_back(cmd_if.cmd);
        log_cyc.push_back(cyc);
        if (cmd_if.cmd == CMD_SODA) soda_cnt++;
      end
      prev_stall = cmd_if.cmd_valid && !cmd_if.cmd_ready;
      prev_cmd   = cmd_if.cmd;
    end
  end

  // Reference: full command list for one purchase, given constant tubes.
  cmd_e exp_q[$];

  function automatic bit plan(int ch, bit de, bit ne);
    int rem = ch;
    exp_q.push_back(CMD_SODA);
    while (rem > 0) begin
      if (rem >= 2 && !de) begin
        exp_q.push_back(CMD_DIME);
        rem -= 2;
      end else if (!ne) begin
        exp_q.push_back(CMD_NICKLE);
        rem -= 1;
      end else begin
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_soda = 1'b0;
    i_change = '0;
    i_dime_empty = 1'b0;
    i_nickle_empty = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({cmd_if.cmd_valid, cmd_if.cmd, o_busy, o_pending, o_overflow, o_change_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b cmd=%0d busy=%0b pending=%0d ovf=%0b err=%0b, want all 0",
               cmd_if.cmd_valid, cmd_if.cmd, o_busy, o_pending, o_overflow, o_change_err);
    end
  endtask

  task automatic test_single();
    int base, c0;
    cmd_e ec[3];
    ec[0] = CMD_SODA; ec[1] = CMD_DIME; ec[2] = CMD_NICKLE;
    do_reset();
    cmd_if.cmd_ready = 1'b1;
    base = log_cmd.size();
    c0 = cyc;
    i_soda = 1'b1; i_change = 3'd3;
    tick();
    i_soda = 1'b0; i_change = '0;
    n_checks++;
    if (o_pending !== 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_entry_visible: pending=%0d busy=%0b, want 1 0", o_pending, o_busy);
    end
    repeat (3) tick();
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_n4: busy=%0b, want 1", o_busy);
    end
    tick();
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_n5: busy=%0b, want 0", o_busy);
    end
    repeat (2) tick();
    n_checks++;
    if (log_cmd.size() - base !== 3) begin
      n_fail++;
      $display("FAIL single_count: transfers=%0d, want 3", log_cmd.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (log_cmd[base+i] !== ec[i] || log_cyc[base+i] !== c0 + 2 + i) begin
          n_fail++;
          $display("FAIL single_seq[%0d]: cmd=%0d cyc=%0d, want cmd=%0d cyc=%0d",
                   i, log_cmd[base+i], log_cyc[base+i] - c0, ec[i], 2 + i);
        end
      end
    end
  endtask

  task automatic test_tubes(int ch, bit de, bit ne, string name);
    int base;
    bit eerr;
    do_reset();
    i_dime_empty = de; i_nickle_empty = ne;
    cmd_if.cmd_ready = 1'b1;
    exp_q.delete();
    eerr = plan(ch, de, ne);
    base = log_cmd.size();
    i_soda = 1'b1; i_change = CHG_WIDTH'(ch);
    tick();
    i_soda = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (log_cmd.size() - base !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: transfers=%0d, want %0d", name, log_cmd.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (log_cmd[base+i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s_seq[%0d]: cmd=%0d, want %0d", name, i, log_cmd[base+i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (o_change_err !== eerr || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_flags: err=%0b busy=%0b, want %0b 0", name, o_change_err, o_busy, eerr);
    end
  endtask

  task automatic test_backpressure();
    int base, pv0, n;
    bit found;
    do_reset();
    cmd_if.cmd_ready = 1'b1;
    base = log_cmd.size();
    pv0 = proto_viol;
    i_soda = 1'b1; i_change = 3'd4;
    tick();
    i_soda = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (cmd_if.cmd_valid && cmd_if.cmd == CMD_DIME) found = 1;
      else tick();
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL bp_dime_seen: no DIME within 10 cycles, want DIME");
    end
    cmd_if.cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd !== CMD_DIME) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%0b cmd=%0d, want 1 %0d", i, cmd_if.cmd_valid, cmd_if.cmd, CMD_DIME);
      end
      tick();
    end
    cmd_if.cmd_ready = 1'b1;
    repeat (5) tick();
    n = log_cmd.size() - base;
    n_checks++;
    if (n !== 3 || log_cmd[base] !== CMD_SODA || log_cmd[base+1] !== CMD_DIME || log_cmd[base+2] !== CMD_DIME) begin
      n_fail++;
      $display("FAIL bp_seq: transfers=%0d, want 3 (SODA DIME DIME)", n);
    end
    n_checks++;
    if (proto_viol - pv0 !== 0 || o_busy !== 1'b0 || o_change_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stable: viol=%0d busy=%0b err=%0b, want 0 0 0", proto_viol - pv0, o_busy, o_change_err);
    end
  endtask

  task automatic test_overflow();
    int s0, maxp, base;
    do_reset();
    base = log_cmd.size();
    s0 = soda_cnt;
    maxp = 0;
    for (int i = 0; i < 6; i++) begin
      i_soda = 1'b1; i_change = '0;
      tick();
      if (int'(o_pending) > maxp) maxp = int'(o_pending);
    end
    i_soda = 1'b0;
    repeat (3) begin
      tick();
      if (int'(o_pending) > maxp) maxp = int'(o_pending);
    end
    n_checks++;
    if (maxp !== 4 || o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_peak: max_pending=%0d ovf=%0b, want 4 1", maxp, o_overflow);
    end
    cmd_if.cmd_ready = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (soda_cnt - s0 !== 5 || log_cmd.size() - base !== 5) begin
      n_fail++;
      $display("FAIL ovf_sodas: sodas=%0d transfers=%0d, want 5 5", soda_cnt - s0, log_cmd.size() - base);
    end
    n_checks++;
    if (o_overflow !== 1'b1 || o_pending !== 0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_after: ovf=%0b pending=%0d busy=%0b, want 1 0 0", o_overflow, o_pending, o_busy);
    end
  endtask

  task automatic test_push_pop_full();
    int s0;
    do_reset();
    s0 = soda_cnt;
    for (int i = 0; i < 5; i++) begin
      i_soda = 1'b1; i_change = '0;
      tick();
    end
    i_soda = 1'b0;
    n_checks++;
    if (o_pending !== 4 || o_overflow !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ppf_full: pending=%0d ovf=%0b busy=%0b, want 4 0 1", o_pending, o_overflow, o_busy);
    end
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    i_soda = 1'b1;
    n_checks++;
    if (o_busy !== 1'b0 || o_pending !== 4) begin
      n_fail++;
      $display("FAIL ppf_idle_full: busy=%0b pending=%0d, want 0 4", o_busy, o_pending);
    end
    tick();
    i_soda = 1'b0;
    n_checks++;
    if (o_pending !== 4 || o_overflow !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ppf_coincide: pending=%0d ovf=%0b busy=%0b, want 4 0 1", o_pending, o_overflow, o_busy);
    end
    cmd_if.cmd_ready = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (soda_cnt - s0 !== 6 || o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ppf_sodas: sodas=%0d ovf=%0b, want 6 0", soda_cnt - s0, o_overflow);
    end
  endtask

  task automatic test_async_reset();
    int lb;
    bit found;
    do_reset();
    cmd_if.cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_soda = 1'b1; i_change = 3'd7;
      tick();
    end
    i_soda = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (cmd_if.cmd_valid && cmd_if.cmd == CMD_DIME) found = 1;
      else tick();
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL arst_dime_seen: no DIME within 10 cycles, want DIME");
    end
    #3;
    i_rst_n = 1'b0;
    #1;
    lb = log_cmd.size();
    n_checks++;
    if ({cmd_if.cmd_valid, cmd_if.cmd, o_busy, o_pending, o_overflow, o_change_err} !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate: valid=%0b cmd=%0d busy=%0b pending=%0d ovf=%0b err=%0b, want all 0",
               cmd_if.cmd_valid, cmd_if.cmd, o_busy, o_pending, o_overflow, o_change_err);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (15) tick();
    n_checks++;
    if (log_cmd.size() !== lb || o_busy !== 1'b0 || o_pending !== 0) begin
      n_fail++;
      $display("FAIL arst_quiet: new_transfers=%0d busy=%0b pending=%0d, want 0 0 0",
               log_cmd.size() - lb, o_busy, o_pending);
    end
  endtask

  task automatic test_random();
    int base, s0, issued, pv0, ch;
    bit de, ne, eerr, done;
    do_reset();
    eerr = 0;
    for (int seg = 0; seg < 4; seg++) begin
      de = 1'($urandom_range(0, 1));
      ne = 1'($urandom_range(0, 1));
      if (seg == 0) begin de = 0; ne = 0; end
      i_dime_empty = de; i_nickle_empty = ne;
      exp_q.delete();
      base = log_cmd.size();
      s0 = soda_cnt;
      pv0 = proto_viol;
      issued = 0;
      for (int t = 0; t < 200; t++) begin
        cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) == 0 && issued - (soda_cnt - s0) <= 3) begin
          ch = int'($urandom_range(0, 7));
          i_soda = 1'b1;
          i_change = CHG_WIDTH'(ch);
          if (plan(ch, de, ne)) eerr = 1;
          issued++;
        end else begin
          i_soda = 1'b0;
          i_change = CHG_WIDTH'($urandom_range(0, 7));
        end
        tick();
      end
      i_soda = 1'b0;
      cmd_if.cmd_ready = 1'b1;
      done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
        tick();
        if (!o_busy && o_pending == 0) done = 1;
      end
      n_checks++;
      if (!done) begin
        n_fail++;
        $display("FAIL rand%0d_drain: busy=%0b pending=%0d, want idle within 200 cycles", seg, o_busy, o_pending);
      end
      n_checks++;
      if (log_cmd.size() - base !== exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: transfers=%0d, want %0d", seg, log_cmd.size() - base, exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_checks++;
          if (log_cmd[base+i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rand%0d_seq[%0d]: cmd=%0d, want %0d", seg, i, log_cmd[base+i], exp_q[i]);
          end
        end
      end
      n_checks++;
      if (o_change_err !== eerr || o_overflow !== 1'b0 || proto_viol - pv0 !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_flags: err=%0b ovf=%0b viol=%0d, want %0b 0 0",
                 seg, o_change_err, o_overflow, proto_viol - pv0, eerr);
      end
    end
  endtask

  initial begin
    cmd_if.cmd_ready = 1'b0;
    test_reset();
    test_single();
    test_tubes(4, 1'b1, 1'b0, "no_dime");
    test_tubes(2, 1'b1, 1'b1, "both_empty");
    test_tubes(5, 1'b0, 1'b1, "no_nickle");
    test_backpressure();
    test_overflow();
    test_push_pop_full();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
